// File: rtl/sm83_pkg.sv
// Shared SM83 bus types and constants: OAM DMA state encoding, register address and transfer size.
package sm83_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } dma_state_t;

    localparam int unsigned DMA_LEN      = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;

    // Sources at 0xE0xx and above alias work RAM through the echo region.
    function automatic logic [7:0] dma_eff_hi(input logic [7:0] src_hi);
        return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares the external bus between the core and the OAM DMA engine; the CPU is locked out
// (reads 0xFF, writes dropped) while a 160-byte copy to OAM is in flight.
module oam_dma_arbiter
    import sm83_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t r_state;
    logic [7:0] r_idx;
    logic [7:0] r_dma_reg;
    logic [7:0] r_data_latch;

    logic       w_reg_hit;
    logic       w_start;
    logic [7:0] w_eff_hi;

    assign w_reg_hit  = (cpu_addr == DMA_REG_ADDR);
    assign w_start    = cpu_wr && w_reg_hit;
    assign w_eff_hi   = dma_eff_hi(r_dma_reg);
    assign dma_active = (r_state == READ) || (r_state == WRITE);

    // A start write wins over whatever the engine was doing, giving restart semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 8'h00;
            r_dma_reg    <= 8'h00;
            r_data_latch <= 8'h00;
        end else if (w_start) begin
            r_dma_reg <= cpu_wdata;
            r_idx     <= 8'h00;
            r_state   <= START;
        end else begin
            case (r_state)
                START: r_state <= READ;
                READ: begin
                    r_data_latch <= mem_rdata;
                    r_state      <= WRITE;
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= 8'h00;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'h01;
                        r_state <= READ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr && !w_reg_hit;
        unique case (r_state)
            READ: begin
                mem_addr  = {w_eff_hi, r_idx};
                mem_wdata = r_data_latch;
                mem_rd    = 1'b1;
                mem_wr    = 1'b0;
            end
            WRITE: begin
                mem_addr  = OAM_BASE + {8'h00, r_idx};
                mem_wdata = r_data_latch;
                mem_rd    = 1'b0;
                mem_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (w_reg_hit) begin
            cpu_rdata = r_dma_reg;
        end else if (dma_active) begin
            cpu_rdata = 8'hFF;
        end else begin
            cpu_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter: a transfer-schedule model predicts every output each cycle.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    int n_checks = 0;
    int n_errs   = 0;
    int act_cnt  = 0;
    int strobe_cnt = 0;

    // Model: phase 0 = idle, 1 = setup cycle, 2 = copying; step k covers byte k/2, read then write.
    int         m_phase;
    int         m_step;
    logic [7:0] m_reg;
    logic [8:0] oam [160];

    oam_dma_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8];
    endfunction

    function automatic logic [7:0] eff(input logic [7:0] h);
        return (h >= 8'hE0) ? h - 8'h20 : h;
    endfunction

    assign mem_rdata = mem_byte(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_step  <= 0;
            m_reg   <= 8'h00;
        end else begin
            if (cpu_wr && cpu_addr == 16'hFF46) begin
                m_reg   <= cpu_wdata;
                m_phase <= 1;
                m_step  <= 0;
                for (int i = 0; i < 160; i++) oam[i] <= 9'h100;
            end else begin
                if (mem_wr && mem_addr >= 16'hFE00 && mem_addr < 16'hFEA0)
                    oam[mem_addr[7:0]] <= {1'b0, mem_wdata};
                if (m_phase == 1) begin
                    m_phase <= 2;
                    m_step  <= 0;
                end else if (m_phase == 2) begin
                    if (m_step == 319) begin
                        m_phase <= 0;
                        m_step  <= 0;
                    end else begin
                        m_step <= m_step + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [15:0] ea;
        logic [7:0]  ewd;
        logic [7:0]  erdata;
        logic [7:0]  src;
        logic [7:0]  idx;
        logic        erd, ewr, eact, chk_wd;
        eact = (m_phase == 2);
        if (eact) begin
            idx = 8'(m_step / 2);
            src = eff(m_reg);
            if (m_step % 2 == 0) begin
                ea = {src, idx}; erd = 1'b1; ewr = 1'b0; ewd = 8'h00; chk_wd = 1'b0;
            end else begin
                ea = 16'hFE00 + {8'h00, idx}; erd = 1'b0; ewr = 1'b1;
                ewd = mem_byte({src, idx}); chk_wd = 1'b1;
            end
        end else begin
            ea = cpu_addr; erd = cpu_rd; ewr = cpu_wr && (cpu_addr != 16'hFF46);
            ewd = cpu_wdata; chk_wd = 1'b1;
        end
        if (cpu_addr == 16'hFF46) erdata = m_reg;
        else if (eact) erdata = 8'hFF;
        else erdata = mem_byte(ea);
        chk("dma_active", 32'(dma_active), 32'(eact));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_rd", 32'(mem_rd), 32'(erd));
        chk("mem_wr", 32'(mem_wr), 32'(ewr));
        if (chk_wd) chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(erdata));
        if (dma_active) act_cnt++;
        if (mem_rd || mem_wr) strobe_cnt++;
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic rd,
                          input logic wr);
        cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic idle_ops(input int n);
        for (int i = 0; i < n; i++) cpu_op(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    // Random CPU traffic that never touches OAM and never starts a transfer.
    task automatic rand_ops(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: cpu_op(16'hC000 + 16'($urandom_range(0, 16'h1FFF)), 8'h00, 1'b1, 1'b0);
                1: cpu_op(16'h8000 + 16'($urandom_range(0, 16'h5FFF)), 8'($urandom), 1'b0,
                          1'b1);
                2: cpu_op(16'hFF46, 8'h00, 1'b1, 1'b0);
                default: cpu_op(16'($urandom), 8'($urandom), 1'b0, 1'b0);
            endcase
        end
    endtask

    task automatic check_oam(input logic [7:0] src_hi, input string tag);
        for (int i = 0; i < 160; i++)
            chk(tag, 32'(oam[i]), 32'({1'b0, 8'(i) ^ 8'h5A ^ src_hi}));
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        for (int i = 0; i < 160; i++) oam[i] = 9'h100;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none
        #1;
        chk("reset dma_active", 32'(dma_active), 32'h0);
        chk("reset mem_rd", 32'(mem_rd), 32'h0);
        chk("reset mem_wr", 32'(mem_wr), 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset cpu_rdata", 32'(cpu_rdata), 32'h5A);
        idle_ops(2);
        rand_ops(40);

        // Transfer from 0xC1xx with CPU traffic during the copy.
        act_cnt = 0;
        cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1);
        chk("start cycle idle", 32'(dma_active), 32'h0);
        idle_ops(1);
        chk("first read addr", 32'(mem_addr), 32'hC100);
        chk("first read strobe", 32'(mem_rd), 32'h1);
        cpu_addr = 16'hC000; cpu_rd = 1'b1;
        #2;
        chk("blocked read data", 32'(cpu_rdata), 32'hFF);
        @(posedge clk); #1; cpu_rd = 1'b0;
        cpu_addr = 16'h8000; cpu_wdata = 8'h33; cpu_wr = 1'b1;
        #2;
        chk("blocked write", 32'(mem_wr && mem_addr == 16'h8000), 32'h0);
        @(posedge clk); #1; cpu_wr = 1'b0;
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        #2;
        chk("dma reg read", 32'(cpu_rdata), 32'hC1);
        @(posedge clk); #1; cpu_rd = 1'b0;
        rand_ops(325);
        chk("active cycles", 32'(act_cnt), 32'd320);
        check_oam(8'hC1, "oam C1");

        // Echo-RAM source.
        cpu_op(16'hFF46, 8'hFE, 1'b0, 1'b1);
        idle_ops(1);
        chk("echo read addr", 32'(mem_addr), 32'hDE00);
        rand_ops(325);
        check_oam(8'hDE, "oam FE");

        // Restart at byte 50.
        cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1);
        idle_ops(101);
        cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_wr = 1'b1;
        #2;
        chk("restart cycle addr", 32'(mem_addr), 32'hC132);
        chk("restart cycle rd", 32'(mem_rd), 32'h1);
        @(posedge clk); #1; cpu_wr = 1'b0;
        chk("restart setup", 32'(dma_active), 32'h0);
        idle_ops(1);
        chk("restart read addr", 32'(mem_addr), 32'hD000);
        rand_ops(325);
        check_oam(8'hD0, "oam D0");

        // Reset in the middle of a transfer.
        cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1);
        idle_ops(161);
        chk("pre-reset addr", 32'(mem_addr), 32'hC150);
        #1 rst_n = 1'b0;
        #1;
        chk("abort dma_active", 32'(dma_active), 32'h0);
        chk("abort mem_rd", 32'(mem_rd), 32'h0);
        chk("abort mem_wr", 32'(mem_wr), 32'h0);
        chk("abort dma reg", 32'(u_dut.cpu_rdata == 8'h00 && cpu_addr == 16'hFF46), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        strobe_cnt = 0;
        idle_ops(40);
        chk("post-reset strobes", 32'(strobe_cnt), 32'h0);
        chk("post-reset active", 32'(dma_active), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
